fu_outbuf: RTL and testbench
============================

FU_OUTBUF -- requirements
Module: fu_outbuf

Interface
REQ-001 The module SHALL have parameter dep, default 4, meaning result-queue depth in entries; it SHALL be a power of two, at least 2.
REQ-002 The module SHALL have parameter ewd, default 2, meaning the number of oldest entries presented per cycle; ewd SHALL be at most dep.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port flush, input, 1 bit: discard all buffered results (pipeline redirect).
REQ-006 The module SHALL have port in_valid, input, 1 bit: the function unit offers a completed result.
REQ-007 The module SHALL have port in_bundle, input, exe_bundle_t: the completed result; opid[15] is set whenever in_valid is high.
REQ-008 The module SHALL have port in_ready, output, 1 bit: the queue accepts a result this cycle.
REQ-009 The module SHALL have port fu_resp, output, exe_bundle_t [ewd-1:0]: the oldest buffered results, with slot 0 the oldest.
REQ-010 The module SHALL have port fu_claim, input, logic [ewd-1:0]: the downstream arbiter takes the corresponding slot this cycle.

Function
REQ-011 State SHALL be: entry array [dep], head pointer, tail pointer (each $clog2(dep) bits, wrapping modulo dep), and count ($clog2(dep)+1 bits, range 0..dep).
REQ-012 in_ready SHALL equal (count < dep), depend only on registered state, and not depend on fu_claim in the same cycle.
REQ-013 An enqueue SHALL occur when in_valid & in_ready; in_bundle SHALL be written at tail, tail SHALL increment by 1 with wrap, and count SHALL increment.
REQ-014 When in_valid is high and in_ready is low, the offer SHALL be ignored with no state change; the function unit holds the result.
REQ-015 fu_resp[j] SHALL equal entry[(head+j) mod dep] when j < count, else all-zero; the output SHALL be combinational from registered state only.
REQ-016 A result enqueued at edge t SHALL be visible on fu_resp from cycle t+1; there SHALL be no same-cycle input-to-output bypass.
REQ-017 Pop count p SHALL be the number of leading consecutive ones in fu_claim, limited to min(count, ewd).
REQ-018 On a pop, head SHALL advance by p with wrap.
REQ-019 Simultaneous enqueue and pop in one cycle SHALL yield count_next = count + enq - p.
REQ-020 Popped entry storage SHALL be left unmodified.
REQ-021 A claim bit set on a slot with index >= count SHALL be ignored.
REQ-022 A claim pattern that is not a contiguous prefix is illegal; only the leading prefix SHALL be honoured.
REQ-023 At full (count = dep), an in-cycle pop SHALL NOT enable an enqueue; the enqueue SHALL wait one cycle.
REQ-024 flush SHALL set head = tail = count = 0 at the next edge and SHALL override any same-cycle enqueue and pop.
REQ-025 During a flush cycle, fu_resp SHALL still reflect pre-flush state, and any claims in that cycle SHALL have no effect.
REQ-026 Order SHALL be strict FIFO: results leave in enqueue order, across pointer wrap-around.

Reset
REQ-027 While rst is high at an edge, head, tail and count SHALL become 0; rst SHALL have priority over flush, enqueue and pop.
REQ-028 After reset, in_ready SHALL be 1 and every fu_resp slot SHALL be all-zero, so opid[15] = 0.
REQ-029 Entry array contents SHALL NOT require reset.
REQ-030 Reset asserted mid-operation SHALL discard all buffered results within one cycle.

Verification
REQ-031 The bench SHALL cover: reset, then enqueue A (opid 0x8001) at cycle 1 -> fu_resp[0].opid = 0x8001 at cycle 2, fu_resp[1] = 0, in_ready = 1.
REQ-032 The bench SHALL cover: with dep=4, enqueue 4 results with no claims -> count 4, in_ready = 0; a fifth offer held for 3 cycles -> no state change, fu_resp[0..1] unchanged.
REQ-033 The bench SHALL cover: full queue, claim = 2'b11 together with in_valid -> 2 popped, enqueue rejected; next cycle in_ready = 1, fu_resp[0] = third-oldest entry.
REQ-034 The bench SHALL cover: count = 1, claim = 2'b11 -> only 1 popped, count = 0; claim = 2'b10 with count 2 -> no pop.
REQ-035 The bench SHALL cover: 10 enqueue/claim-1 cycles forcing head and tail wrap -> the opid sequence out equals the sequence in; count never exceeds 4.
REQ-036 The bench SHALL cover: count 3, flush with in_valid and claim = 2'b01 in the same cycle -> next cycle count 0, all fu_resp zero, in_ready = 1.

Source files
------------

// File: rtl/fu_outbuf.sv
// Function-unit result queue: buffers completed results and presents the
// oldest ewd entries to a downstream arbiter, which claims a leading prefix.

package fu_outbuf_pkg;
    typedef struct packed {
        logic [15:0] opid;     // opid[15] marks a live result
        logic [31:0] result;
        logic [4:0]  rd;
        logic        exc;
    } exe_bundle_t;
endpackage

module fu_outbuf
    import fu_outbuf_pkg::*;
#(
    parameter int dep = 4,
    parameter int ewd = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    input  exe_bundle_t           in_bundle,
    output logic                  in_ready,
    output exe_bundle_t [ewd-1:0] fu_resp,
    input  logic [ewd-1:0]        fu_claim
);

    localparam int AW = $clog2(dep);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEP_C = CW'(dep);

    logic [AW-1:0] head_reg;
    logic [AW-1:0] tail_reg;
    logic [CW-1:0] count_reg;
    logic [AW-1:0] head_next;
    logic [AW-1:0] tail_next;
    logic [CW-1:0] count_next;
    exe_bundle_t   entry_mem [dep];

    logic          enq;
    logic [ewd:0]  claim_run;
    logic [CW-1:0] pop_cnt;

    // Ready comes from the registered count only, so a same-cycle pop never
    // frees a slot for an incoming result.
    assign in_ready = (count_reg < DEP_C);
    assign enq      = in_valid & in_ready;

    // claim_run[j+1] is set while slots 0..j are all claimed and occupied;
    // the first gap or empty slot ends the honoured prefix.
    assign claim_run[0] = 1'b1;
    generate
        for (genvar gi = 0; gi < ewd; gi++) begin : g_claim
            assign claim_run[gi+1] = claim_run[gi] & fu_claim[gi]
                                   & (CW'(gi) < count_reg);
        end
    endgenerate

    always_comb begin
        pop_cnt = '0;
        for (int j = 1; j <= ewd; j++) begin
            pop_cnt = pop_cnt + CW'(claim_run[j]);
        end
    end

    assign head_next  = head_reg + AW'(pop_cnt);
    assign tail_next  = tail_reg + AW'(enq);
    assign count_next = count_reg + CW'(enq) - pop_cnt;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    // Storage has no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (!rst && !flush && enq) begin
            entry_mem[tail_reg] <= in_bundle;
        end
    end

    generate
        for (genvar gi = 0; gi < ewd; gi++) begin : g_resp
            assign fu_resp[gi] = (CW'(gi) < count_reg)
                               ? entry_mem[head_reg + AW'(gi)]
                               : '0;
        end
    endgenerate

endmodule

// File: tb/tb_fu_outbuf.sv
// Directed plus randomized checking of fu_outbuf against a queue-based model.

module tb_fu_outbuf;
    import fu_outbuf_pkg::*;

    localparam int DEP = 4;
    localparam int EWD = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  flush;
    logic                  in_valid;
    exe_bundle_t           in_bundle;
    logic                  in_ready;
    exe_bundle_t [EWD-1:0] fu_resp;
    logic [EWD-1:0]        fu_claim;

    int tests = 0;
    int fails = 0;

    exe_bundle_t q[$];
    exe_bundle_t sent[$];
    logic [15:0] popped[$];
    exe_bundle_t saved[$];

    always #5 clk = ~clk;

    fu_outbuf #(.dep(DEP), .ewd(EWD)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_bundle(in_bundle),
        .in_ready (in_ready),
        .fu_resp  (fu_resp),
        .fu_claim (fu_claim)
    );

    function automatic exe_bundle_t rand_bundle();
        exe_bundle_t b;
        b.opid   = {1'b1, 15'($urandom)};
        b.result = $urandom;
        b.rd     = 5'($urandom);
        b.exc    = 1'($urandom);
        return b;
    endfunction

    task automatic check_all(input string tag);
        exe_bundle_t exp;
        logic exp_rdy;
        exp_rdy = (q.size() < DEP);
        tests++;
        assert (in_ready === exp_rdy) else begin
            fails++;
            $error("FAIL %s in_ready got=%0b exp=%0b", tag, in_ready, exp_rdy);
        end
        for (int j = 0; j < EWD; j++) begin
            exp = (j < q.size()) ? q[j] : '0;
            tests++;
            assert (fu_resp[j] === exp) else begin
                fails++;
                $error("FAIL %s fu_resp[%0d] got=%h exp=%h", tag, j, fu_resp[j], exp);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Model update from the inputs presented this cycle, then clock and check.
    task automatic tick(input string tag);
        int  sz;
        int  p;
        bit  run;
        bit  rdy;
        sz  = q.size();
        rdy = (sz < DEP);
        if (rst || flush) begin
            q.delete();
        end else begin
            p   = 0;
            run = 1'b1;
            for (int j = 0; j < EWD; j++) begin
                if (run && fu_claim[j] && j < sz) p++;
                else run = 1'b0;
            end
            for (int k = 0; k < p; k++) void'(q.pop_front());
            if (in_valid && rdy) q.push_back(in_bundle);
        end
        @(posedge clk);
        #1;
        $display("[TB] %s v=%0b cl=%b fl=%0b rst=%0b rdy=%0b r0=%h r1=%h n=%0d",
                 tag, in_valid, fu_claim, flush, rst, in_ready,
                 fu_resp[0].opid, fu_resp[1].opid, q.size());
        check_all(tag);
    endtask

    task automatic idle_inputs();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; fu_claim = '0; in_bundle = '0;
    endtask

    task automatic drain();
        idle_inputs();
        fu_claim = 2'b11;
        for (int i = 0; i < 2 * DEP && q.size() > 0; i++) tick("drain");
        chk("drain_empty", 32'(q.size()), 32'd0);
        fu_claim = '0;
    endtask

    initial begin
        exe_bundle_t b;
        idle_inputs();
        rst = 1'b1;
        tick("reset");
        tick("reset");
        rst = 1'b0;
        chk("rst_ready", 32'(in_ready), 32'd1);

        // Single result visible the cycle after its enqueue.
        in_valid = 1'b1;
        in_bundle = rand_bundle();
        in_bundle.opid = 16'h8001;
        tick("enq_a");
        in_valid = 1'b0;
        chk("a_opid", 32'(fu_resp[0].opid), 32'h8001);
        chk("a_slot1", 32'(fu_resp[1]), 32'd0);

        // Fill to full, then hold a fifth offer for three cycles.
        saved.delete();
        saved.push_back(q[0]);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_bundle = rand_bundle();
            saved.push_back(in_bundle);
            tick("fill");
        end
        chk("full_ready", 32'(in_ready), 32'd0);
        in_bundle = rand_bundle();
        for (int i = 0; i < 3; i++) begin
            tick("hold5");
            chk("hold_r0", 32'(fu_resp[0].opid), 32'(saved[0].opid));
            chk("hold_r1", 32'(fu_resp[1].opid), 32'(saved[1].opid));
        end

        // Pop two at full with a simultaneous offer: enqueue must be refused.
        fu_claim = 2'b11;
        tick("pop2_full");
        fu_claim = 2'b00;
        in_valid = 1'b0;
        chk("pop2_ready", 32'(in_ready), 32'd1);
        chk("pop2_r0", 32'(fu_resp[0].opid), 32'(saved[2].opid));

        // Prefix limited by occupancy, and a non-prefix claim pops nothing.
        fu_claim = 2'b01;
        tick("pop1");
        fu_claim = 2'b11;
        tick("claim11_cnt1");
        chk("cnt1_empty", 32'(fu_resp[0].opid[15]), 32'd0);
        fu_claim = 2'b00;
        in_valid = 1'b1;
        in_bundle = rand_bundle();
        tick("enq");
        in_bundle = rand_bundle();
        tick("enq");
        in_valid = 1'b0;
        b = q[0];
        fu_claim = 2'b10;
        tick("claim10");
        chk("claim10_r0", 32'(fu_resp[0].opid), 32'(b.opid));
        drain();

        // Ten enqueue/claim-one cycles wrapping both pointers.
        sent.delete();
        popped.delete();
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_bundle = rand_bundle();
            sent.push_back(in_bundle);
            fu_claim = 2'b01;
            if (fu_resp[0].opid[15]) popped.push_back(fu_resp[0].opid);
            tick("wrap");
            chk("wrap_ready", 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4 && fu_resp[0].opid[15]; i++) begin
            popped.push_back(fu_resp[0].opid);
            tick("wrap_tail");
        end
        chk("wrap_len", 32'(popped.size()), 32'd10);
        for (int i = 0; i < 10 && i < popped.size(); i++)
            chk("wrap_order", 32'(popped[i]), 32'(sent[i].opid));
        fu_claim = '0;

        // Flush with a same-cycle offer and claim.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_bundle = rand_bundle();
            tick("pre_flush");
        end
        b = q[0];
        flush = 1'b1;
        in_valid = 1'b1;
        in_bundle = rand_bundle();
        fu_claim = 2'b01;
        #1;
        chk("flush_pre_r0", 32'(fu_resp[0].opid), 32'(b.opid));
        tick("flush");
        idle_inputs();
        chk("flush_ready", 32'(in_ready), 32'd1);
        chk("flush_r0", 32'(fu_resp[0]), 32'd0);

        // Reset arriving with results buffered.
        in_valid = 1'b1;
        in_bundle = rand_bundle();
        tick("enq");
        in_bundle = rand_bundle();
        tick("enq");
        rst = 1'b1;
        in_bundle = rand_bundle();
        fu_claim = 2'b01;
        tick("mid_reset");
        idle_inputs();
        chk("midrst_r0", 32'(fu_resp[0].opid), 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            rst      = ($urandom_range(0, 59) == 0);
            flush    = ($urandom_range(0, 29) == 0);
            in_valid = ($urandom_range(0, 99) < 60);
            in_bundle = in_valid ? rand_bundle() : exe_bundle_t'('0);
            fu_claim = 2'($urandom);
            tick("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout tests=%0d", tests);
        $fatal(1, "timeout");
    end

endmodule
